// File: rtl/pc_seq_ctl_pkg.sv
// rtl/pc_seq_ctl_pkg.sv - shared PC pre-control codes and sequencer state codes
package pc_seq_ctl_pkg;

    localparam logic [3:0] PC_IGN = 4'b0001;
    localparam logic [3:0] PC_KEP = 4'b0010;
    localparam logic [3:0] PC_IRQ = 4'b0100;
    localparam logic [3:0] PC_RST = 4'b1000;

    typedef enum logic [1:0] {
        PCS_RST  = 2'd0,
        PCS_RUN  = 2'd1,
        PCS_IRQ  = 2'd2,
        PCS_MASK = 2'd3
    } pcs_t;

endpackage

// File: rtl/pc_seq_ctl_stat_cnt.sv
// rtl/pc_seq_ctl_stat_cnt.sv - debug event counter, optionally saturating
module stat_cnt #(
    parameter int W   = 16,
    parameter bit SAT = 1'b1
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(SAT && (&cnt))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pc_seq_ctl.sv
// rtl/pc_seq_ctl.sv - front-end PC sequencer: reset hold, stalls, interrupt redirect
module pc_seq_ctl
    import pc_seq_ctl_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int STALL_CW   = 16,
    parameter int IRQ_CW     = 8
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                irq_req,
    input  logic                irq_en,
    input  logic                in_delay_slot,
    input  logic                lu_hazard,
    input  logic                md_busy,
    input  logic                cnt_clr,
    output logic [3:0]          pc_prectl,
    output logic                rd_clk_cls,
    output logic                pipe_stall,
    output logic                pipe_flush,
    output logic                irq_ack,
    output logic                spc_we,
    output logic [STALL_CW-1:0] stall_cnt,
    output logic [IRQ_CW-1:0]   irq_cnt
);

    pcs_t       state, state_nxt;
    logic [3:0] hold_cnt;
    logic       stall_req;
    logic       stall_inc;
    logic       irq_inc;

    assign stall_req = lu_hazard | md_busy;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PCS_RST;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == PCS_RST) ? hold_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_prectl  = PC_IGN;
        rd_clk_cls = 1'b0;
        pipe_stall = 1'b0;
        pipe_flush = 1'b0;
        irq_ack    = 1'b0;
        spc_we     = 1'b0;
        stall_inc  = 1'b0;
        irq_inc    = 1'b0;
        case (state)
            PCS_RST: begin
                pc_prectl  = PC_RST;
                rd_clk_cls = 1'b1;
                pipe_stall = 1'b1;
                if (hold_cnt == 4'(RST_CYCLES - 1))
                    state_nxt = PCS_RUN;
            end
            PCS_RUN, PCS_MASK: begin
                if (stall_req) begin
                    pc_prectl  = PC_KEP;
                    rd_clk_cls = 1'b1;
                    pipe_stall = 1'b1;
                    stall_inc  = 1'b1;
                end
                if (state == PCS_RUN) begin
                    if (irq_req && irq_en && !in_delay_slot && !stall_req)
                        state_nxt = PCS_IRQ;
                end else if (!irq_req) begin
                    // level must drop before another request can be taken
                    state_nxt = PCS_RUN;
                end
            end
            PCS_IRQ: begin
                pc_prectl  = PC_IRQ;
                pipe_flush = 1'b1;
                irq_ack    = 1'b1;
                spc_we     = 1'b1;
                irq_inc    = 1'b1;
                state_nxt  = PCS_MASK;
            end
            default: state_nxt = PCS_RST;
        endcase
    end

    stat_cnt #(.W(STALL_CW), .SAT(1'b1)) u_stall_cnt (
        .clock (clock),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    stat_cnt #(.W(IRQ_CW), .SAT(1'b0)) u_irq_cnt (
        .clock (clock),
        .rst_n (rst_n),
        .inc   (irq_inc),
        .clr   (cnt_clr),
        .cnt   (irq_cnt)
    );

endmodule

// File: tb/tb_pc_seq_ctl.sv
// tb/tb_pc_seq_ctl.sv - directed and randomized checks of pc_seq_ctl against a behavioural model
module tb_pc_seq_ctl;
    import pc_seq_ctl_pkg::*;

    localparam int RSTC = 4;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        irq_req, irq_en, in_delay_slot, lu_hazard, md_busy, cnt_clr;
    logic [3:0]  pc_prectl;
    logic        rd_clk_cls, pipe_stall, pipe_flush, irq_ack, spc_we;
    logic [15:0] stall_cnt;
    logic [7:0]  irq_cnt;

    int total = 0;
    int bad   = 0;

    bit m_rst, m_ack, m_mask;
    int m_hold, m_scnt, m_icnt;

    pc_seq_ctl #(.RST_CYCLES(RSTC), .STALL_CW(16), .IRQ_CW(8)) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .irq_req       (irq_req),
        .irq_en        (irq_en),
        .in_delay_slot (in_delay_slot),
        .lu_hazard     (lu_hazard),
        .md_busy       (md_busy),
        .cnt_clr       (cnt_clr),
        .pc_prectl     (pc_prectl),
        .rd_clk_cls    (rd_clk_cls),
        .pipe_stall    (pipe_stall),
        .pipe_flush    (pipe_flush),
        .irq_ack       (irq_ack),
        .spc_we        (spc_we),
        .stall_cnt     (stall_cnt),
        .irq_cnt       (irq_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rst  = 1'b1;
        m_hold = 0;
        m_ack  = 1'b0;
        m_mask = 1'b0;
        m_scnt = 0;
        m_icnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},    32'(pc_prectl),  32'(PC_RST));
        check({tag, "_rd"},    32'(rd_clk_cls), 32'd1);
        check({tag, "_stall"}, 32'(pipe_stall), 32'd1);
        check({tag, "_ack"},   32'({irq_ack, spc_we, pipe_flush}), 32'd0);
        check({tag, "_cnts"},  32'({stall_cnt, irq_cnt}), 32'd0);
    endtask

    // One clock: inputs applied just after the rising edge, outputs checked
    // at the falling edge, model advanced at the next rising edge.
    task automatic cyc(input bit lu, input bit md, input bit ir, input bit en,
                       input bit ds, input bit clr);
        bit         st;
        logic [3:0] e_pc;
        bit         e_hold, e_irq;
        lu_hazard = lu; md_busy = md; irq_req = ir;
        irq_en = en; in_delay_slot = ds; cnt_clr = clr;
        st = lu | md;
        if (m_rst) begin
            e_pc = PC_RST; e_hold = 1'b1; e_irq = 1'b0;
        end else if (m_ack) begin
            e_pc = PC_IRQ; e_hold = 1'b0; e_irq = 1'b1;
        end else begin
            e_pc = st ? PC_KEP : PC_IGN; e_hold = st; e_irq = 1'b0;
        end
        @(negedge clock);
        check("pc_prectl",  32'(pc_prectl),  32'(e_pc));
        check("rd_clk_cls", 32'(rd_clk_cls), 32'(e_hold));
        check("pipe_stall", 32'(pipe_stall), 32'(e_hold));
        check("pipe_flush", 32'(pipe_flush), 32'(e_irq));
        check("irq_ack",    32'(irq_ack),    32'(e_irq));
        check("spc_we",     32'(spc_we),     32'(e_irq));
        check("stall_cnt",  32'(stall_cnt),  32'(m_scnt));
        check("irq_cnt",    32'(irq_cnt),    32'(m_icnt));
        @(posedge clock);
        if (!m_rst && !m_ack && st) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
        if (m_ack) m_icnt = (m_icnt + 1) % 256;
        if (clr) begin m_scnt = 0; m_icnt = 0; end
        if (m_rst) begin
            m_hold++;
            if (m_hold == RSTC) m_rst = 1'b0;
        end else if (m_ack) begin
            m_ack = 1'b0; m_mask = 1'b1;
        end else if (m_mask) begin
            if (!ir) m_mask = 1'b0;
        end else if (ir && en && !ds && !st) begin
            m_ack = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {irq_req, irq_en, in_delay_slot, lu_hazard, md_busy, cnt_clr} = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        repeat (RSTC + 1) cyc(0, 0, 0, 0, 0, 0);

        // load-use for one cycle, mul/div busy for three
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("stall_cnt_4", 32'(stall_cnt), 32'd4);

        // request held off by a delay slot, then accepted
        repeat (2) cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        check("irq_cnt_1", 32'(irq_cnt), 32'd1);

        // held level must not re-trigger; drop and raise re-arms
        repeat (10) cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        check("irq_cnt_2", 32'(irq_cnt), 32'd2);
        cyc(0, 0, 0, 1, 0, 0);

        // stall beats interrupt until md_busy falls
        repeat (3) cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("irq_cnt_3", 32'(irq_cnt), 32'd3);

        // stall counter saturation, then clear beating increment
        cyc(0, 0, 0, 0, 0, 1);
        repeat (65534) cyc(0, 1, 0, 0, 0, 0);
        check("stall_cnt_fffe", 32'(stall_cnt), 32'hFFFE);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        check("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
        cyc(0, 1, 0, 0, 0, 1);
        check("stall_cnt_clr", 32'(stall_cnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(7) == 0), ($urandom_range(5) == 0),
                ($urandom_range(2) != 0), ($urandom_range(3) != 0),
                ($urandom_range(3) == 0), ($urandom_range(63) == 0));
        end

        // reset asserted while in the redirect cycle
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        check("irq_ack_before_rst", 32'(irq_ack), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (RSTC + 3) cyc(0, 0, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
